// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and helpers for the operand forwarding unit
package fwd_pkg;

   localparam int FWD_DATA_W      = 32;
   localparam int FWD_ADDR_W      = 5;
   localparam int FWD_SEL_REGFILE = 0;

   // One history slot; this layout fixes the operand and register index widths
   typedef struct packed {
      logic                  valid;
      logic [FWD_ADDR_W-1:0] rd;
      logic [FWD_DATA_W-1:0] data;
      logic                  ready;
   } fwd_entry_t;

   function automatic int fwd_sel_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_lookup.sv
// rtl/fwd_lookup.sv - youngest-match forwarding lookup for one source operand
module fwd_lookup
   import fwd_pkg::*;
#(
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 1,
   parameter int SEL_W      = fwd_sel_w(DEPTH)
) (
   input  fwd_entry_t [DEPTH-1:0] hist,
   input  logic [FWD_ADDR_W-1:0]  src_rd,
   input  logic [FWD_DATA_W-1:0]  rf_data,
   input  logic                   late_valid,
   input  logic [FWD_DATA_W-1:0]  late_data,
   output logic [FWD_DATA_W-1:0]  data,
   output logic [SEL_W-1:0]       sel,
   output logic                   hazard
);

   // Scan youngest first; the first valid match decides, older matches are shadowed
   always_comb begin
      logic found;
      found  = 1'b0;
      data   = rf_data;
      sel    = SEL_W'(FWD_SEL_REGFILE);
      hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!found && hist[i].valid && (hist[i].rd == src_rd) && (src_rd != '0)) begin
            found = 1'b1;
            sel   = SEL_W'(i + 1);
            if (hist[i].ready) begin
               data = hist[i].data;
            end else if ((i == LOAD_STAGE) && late_valid) begin
               data = late_data;
            end else begin
               hazard = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/operand_forward_unit.sv
// rtl/operand_forward_unit.sv - history-buffer operand forwarding with load-use stall detection
module operand_forward_unit
   import fwd_pkg::*;
#(
   parameter int  DATA_W     = FWD_DATA_W,
   parameter int  ADDR_W     = FWD_ADDR_W,
   parameter int  DEPTH      = 3,
   parameter int  NUM_SRC    = 2,
   parameter int  LOAD_STAGE = 1,
   parameter int  CNT_W      = 16,
   localparam int SEL_W      = fwd_sel_w(DEPTH)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       hold_i,
   input  logic                       flush_i,
   input  logic                       push_valid_i,
   input  logic                       push_we_i,
   input  logic [ADDR_W-1:0]          push_rd_i,
   input  logic [DATA_W-1:0]          push_data_i,
   input  logic                       push_ready_i,
   input  logic                       late_valid_i,
   input  logic [DATA_W-1:0]          late_data_i,
   input  logic [NUM_SRC-1:0]         src_used_i,
   input  logic [NUM_SRC*ADDR_W-1:0]  src_rd_i,
   input  logic [NUM_SRC*DATA_W-1:0]  rf_data_i,
   output logic [NUM_SRC*DATA_W-1:0]  data_o,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
   output logic                       stall_o,
   output logic [CNT_W-1:0]           stall_cnt_o
);

   fwd_entry_t [DEPTH-1:0] hist_q;
   fwd_entry_t             ls_next;
   logic [NUM_SRC-1:0]     hazard;

   // Entry at LOAD_STAGE with any pending late load data folded in
   always_comb begin
      ls_next = hist_q[LOAD_STAGE];
      if (late_valid_i && hist_q[LOAD_STAGE].valid && !hist_q[LOAD_STAGE].ready) begin
         ls_next.data  = late_data_i;
         ls_next.ready = 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      fwd_lookup #(
         .DEPTH      (DEPTH),
         .LOAD_STAGE (LOAD_STAGE),
         .SEL_W      (SEL_W)
      ) u_lookup (
         .hist       (hist_q),
         .src_rd     (src_rd_i[k*ADDR_W +: ADDR_W]),
         .rf_data    (rf_data_i[k*DATA_W +: DATA_W]),
         .late_valid (late_valid_i),
         .late_data  (late_data_i),
         .data       (data_o[k*DATA_W +: DATA_W]),
         .sel        (fwd_sel_o[k*SEL_W +: SEL_W]),
         .hazard     (hazard[k])
      );
   end

   assign stall_o = |(src_used_i & hazard);

   // History buffer: flush beats hold beats shift; a stalled push enters as a bubble
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hist_q <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            hist_q[i].valid <= 1'b0;
         end
      end else if (hold_i) begin
         hist_q[LOAD_STAGE] <= ls_next;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            hist_q[i] <= ((i - 1) == LOAD_STAGE) ? ls_next : hist_q[i-1];
         end
         hist_q[0] <= '{valid: push_valid_i & push_we_i & ~stall_o,
                        rd:    push_rd_i,
                        data:  push_data_i,
                        ready: push_ready_i};
      end
   end

   // Saturating count of stall cycles that actually advance the pipeline
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_o <= '0;
      end else if (!flush_i && !hold_i && stall_o && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

   // A load must collect its data before it moves past LOAD_STAGE
   for (genvar g = LOAD_STAGE + 1; g < DEPTH; g++) begin : g_late_chk
      a_late_in_time: assert property (@(posedge clk_i) disable iff (!rst_i)
         !(hist_q[g].valid && !hist_q[g].ready));
   end

endmodule

// File: tb/tb_operand_forward_unit.sv
// tb/tb_operand_forward_unit.sv - directed vector bench for operand_forward_unit
module tb_operand_forward_unit;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;
   localparam int NUM_SRC = 2;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 4;

   logic                      clk = 1'b0;
   logic                      rst = 1'b0;
   logic                      hold = 1'b0, flush = 1'b0;
   logic                      push_valid = 1'b0, push_we = 1'b0, push_ready = 1'b0;
   logic [ADDR_W-1:0]         push_rd = '0;
   logic [DATA_W-1:0]         push_data = '0;
   logic                      late_valid = 1'b0;
   logic [DATA_W-1:0]         late_data = '0;
   logic [NUM_SRC-1:0]        src_used = '0;
   logic [NUM_SRC*ADDR_W-1:0] src_rd = '0;
   logic [NUM_SRC*DATA_W-1:0] rf_data = '0;
   logic [NUM_SRC*DATA_W-1:0] data_o;
   logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
   logic                      stall;
   logic [CNT_W-1:0]          stall_cnt;

   operand_forward_unit #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(3), .NUM_SRC(NUM_SRC),
      .LOAD_STAGE(1), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
      .push_valid_i(push_valid), .push_we_i(push_we), .push_rd_i(push_rd),
      .push_data_i(push_data), .push_ready_i(push_ready),
      .late_valid_i(late_valid), .late_data_i(late_data),
      .src_used_i(src_used), .src_rd_i(src_rd), .rf_data_i(rf_data),
      .data_o(data_o), .fwd_sel_o(fwd_sel), .stall_o(stall), .stall_cnt_o(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hold, flush, pv, pwe, prdy;
      logic [4:0]  prd;
      logic [31:0] pdata;
      logic        lv;
      logic [31:0] ldata;
      logic [1:0]  used;
      logic [4:0]  s0, s1;
      logic        ck0;
      logic [1:0]  sel0;
      logic [31:0] d0;
      logic        ck1;
      logic [1:0]  sel1;
      logic [31:0] d1;
      logic        stall;
      logic [3:0]  cnt;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
      end
   endtask

   task automatic add(input logic hold_v, flush_v, pv, pwe, prdy, input logic [4:0] prd,
                      input logic [31:0] pdata, input logic lv, input logic [31:0] ldata,
                      input logic [1:0] used, input logic [4:0] s0, s1,
                      input logic ck0, input logic [1:0] sel0, input logic [31:0] d0,
                      input logic ck1, input logic [1:0] sel1, input logic [31:0] d1,
                      input logic stall_v, input logic [3:0] cnt);
      vec_t v;
      v = '{hold_v, flush_v, pv, pwe, prdy, prd, pdata, lv, ldata, used, s0, s1,
            ck0, sel0, d0, ck1, sel1, d1, stall_v, cnt};
      vecs.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        v;
      logic [31:0] rf0, rf1;
      //   hold flush pv we rdy rd  pdata     lv ldata     used  s0  s1  ck0 sel0 d0     ck1 sel1 d1     stall cnt
      add(0, 0, 0, 0, 0,  0, 32'h0,    0, 32'h0,  2'b11,  5,  7, 1, 0, 32'h0,  1, 0, 32'h0,  0, 0);
      add(0, 0, 1, 1, 1,  5, 32'h11,   0, 32'h0,  2'b00,  0,  0, 1, 0, 32'h0,  1, 0, 32'h0,  0, 0);
      add(0, 0, 1, 1, 0,  7, 32'hDEAD, 0, 32'h0,  2'b11,  5,  7, 1, 1, 32'h11, 1, 0, 32'h0,  0, 0);
      add(0, 0, 1, 1, 1,  8, 32'h99,   0, 32'h0,  2'b11,  7,  5, 0, 0, 32'h0,  1, 2, 32'h11, 1, 0);
      add(0, 0, 1, 1, 1,  3, 32'h1,    1, 32'hAB, 2'b11,  7,  8, 1, 2, 32'hAB, 1, 0, 32'h0,  0, 1);
      add(0, 0, 1, 1, 1,  3, 32'h2,    0, 32'h0,  2'b11,  3,  7, 1, 1, 32'h1,  1, 3, 32'hAB, 0, 1);
      add(0, 0, 1, 1, 1,  0, 32'h55,   0, 32'h0,  2'b11,  3,  7, 1, 1, 32'h2,  1, 0, 32'h0,  0, 1);
      add(0, 0, 1, 1, 0,  9, 32'h0,    0, 32'h0,  2'b11,  0,  3, 1, 0, 32'h0,  1, 2, 32'h2,  0, 1);
      add(0, 0, 1, 0, 1,  3, 32'h999,  0, 32'h0,  2'b01,  3,  9, 1, 3, 32'h2,  0, 0, 32'h0,  0, 1);
      add(1, 0, 1, 1, 1, 12, 32'h12,   0, 32'h0,  2'b11,  3,  9, 1, 0, 32'h0,  0, 0, 32'h0,  1, 1);
      add(1, 0, 1, 1, 1, 12, 32'h12,   0, 32'h0,  2'b11, 12,  9, 1, 0, 32'h0,  0, 0, 32'h0,  1, 1);
      add(1, 0, 1, 1, 1, 12, 32'h12,   1, 32'hCD, 2'b11, 12,  9, 1, 0, 32'h0,  1, 2, 32'hCD, 0, 1);
      add(0, 1, 1, 1, 1, 13, 32'h77,   0, 32'h0,  2'b11, 13,  9, 1, 0, 32'h0,  1, 2, 32'hCD, 0, 1);
      add(0, 0, 0, 0, 0,  0, 32'h0,    0, 32'h0,  2'b11, 13,  9, 1, 0, 32'h0,  1, 0, 32'h0,  0, 1);

      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;

      for (int n = 0; n < vecs.size(); n++) begin
         v = vecs[n];
         rf0 = 32'hA000_0000 | n;
         rf1 = 32'hB000_0000 | n;
         hold = v.hold; flush = v.flush;
         push_valid = v.pv; push_we = v.pwe; push_ready = v.prdy;
         push_rd = v.prd; push_data = v.pdata;
         late_valid = v.lv; late_data = v.ldata;
         src_used = v.used; src_rd = {v.s1, v.s0};
         rf_data = {rf1, rf0};
         #1;
         if (v.ck0) begin
            check($sformatf("v%0d data0", n), data_o[31:0], (v.sel0 == 2'd0) ? rf0 : v.d0);
            check($sformatf("v%0d sel0", n), {30'b0, fwd_sel[1:0]}, {30'b0, v.sel0});
         end
         if (v.ck1) begin
            check($sformatf("v%0d data1", n), data_o[63:32], (v.sel1 == 2'd0) ? rf1 : v.d1);
            check($sformatf("v%0d sel1", n), {30'b0, fwd_sel[3:2]}, {30'b0, v.sel1});
         end
         check($sformatf("v%0d stall", n), {31'b0, stall}, {31'b0, v.stall});
         check($sformatf("v%0d cnt", n), {28'b0, stall_cnt}, {28'b0, v.cnt});
         @(posedge clk);
         #1;
      end

      hold = 1'b0; flush = 1'b0; late_valid = 1'b0;
      rf_data = {32'hB000_00FF, 32'hA000_00FF};
      push_valid = 1'b1; push_we = 1'b1; push_ready = 1'b0; push_rd = 5'd4; push_data = '0;
      src_used = 2'b00; src_rd = {5'd0, 5'd4};
      @(posedge clk);
      #1;
      push_valid = 1'b0; src_used = 2'b01;
      #1 check("rst_seq stall_ex", {31'b0, stall}, 32'd1);
      @(posedge clk);
      #1 check("rst_seq cnt_before", {28'b0, stall_cnt}, 32'd2);
      #1 check("rst_seq stall_ls", {31'b0, stall}, 32'd1);
      rst = 1'b0;
      #1;
      check("rst_async stall", {31'b0, stall}, 32'd0);
      check("rst_async cnt", {28'b0, stall_cnt}, 32'd0);
      check("rst_async data0", data_o[31:0], 32'hA000_00FF);
      check("rst_async sel0", {30'b0, fwd_sel[1:0]}, 32'd0);
      #1 rst = 1'b1;

      for (int it = 0; it < 20; it++) begin
         push_valid = 1'b1; push_we = 1'b1; push_ready = 1'b0; push_rd = 5'd7;
         late_valid = 1'b1; late_data = it;
         src_used = 2'b00; src_rd = {5'd0, 5'd7};
         @(posedge clk);
         #1;
         push_valid = 1'b0; late_valid = 1'b0; src_used = 2'b01;
         #1 check($sformatf("sat it%0d stall", it), {31'b0, stall}, 32'd1);
         @(posedge clk);
         #1;
         if (it == 13) check("sat cnt14", {28'b0, stall_cnt}, 32'd14);
      end
      check("sat cnt15", {28'b0, stall_cnt}, 32'd15);
      src_used = 2'b00; flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
